dram_mig_bridge: RTL and testbench

//  Responder side of the single-word DRAM request port driven by the CPU memory arbiter.

---
 rtl/dram_mig_bridge_if.sv | 32 +++
 rtl/dram_mig_bridge.sv | 138 +++++++++++++
 tb/tb_dram_mig_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_mig_bridge_if.sv
// MIG user-interface (UI) bundle between the DRAM bridge and the MIG core.
//   app_addr/app_cmd/app_en, app_rdy     : command channel
//   app_wdf_data/mask/wren/end, wdf_rdy  : write-data channel
//   app_rd_data/app_rd_data_valid        : read-data return
// The master modport is the bridge side. The slave modport is the MIG core side.
interface dram_mig_bridge_if #(
  parameter int APP_AW = 27
);
  logic [APP_AW-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [127:0]      app_wdf_data;
  logic [15:0]       app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [127:0]      app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/dram_mig_bridge.sv
// Responder for the single-word DRAM request port from the CPU memory arbiter.
// Each one-cycle dram_oe request becomes one 128-bit MIG UI transaction.
// A read returns the addressed 32-bit lane. A write is a byte-masked write of one lane.
// Only one request is in flight at a time.
// Ports:
//   clk, rst            : UI clock and synchronous active-high reset
//   init_calib_complete : MIG calibration done; commands are held back while low
//   dram_oe/addr/wdata/we : request strobe and payload (we==0 means read)
//   dram_rdata/dram_valid : read data and its one-cycle completion pulse
//   dram_written          : one-cycle write completion pulse
//   mig                   : MIG UI bundle (master side)
module dram_mig_bridge #(
  parameter int MEM_SCALE = 27,
  parameter int APP_AW    = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_calib_complete,
  input  logic                 dram_oe,
  input  logic [MEM_SCALE-1:0] dram_addr,
  input  logic [31:0]          dram_wdata,
  input  logic [3:0]           dram_we,
  output logic [31:0]          dram_rdata,
  output logic                 dram_valid,
  output logic                 dram_written,
  dram_mig_bridge_if.master    mig
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_RDATA, S_WR} state_t;

  state_t     state;
  logic [1:0] lane_q;
  logic       is_wr_q;
  logic       cmd_done;
  logic       wdf_done;

  // The byte offset within a word plays no part in the transaction.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dram_addr[1:0];

  logic cmd_acc;
  logic wdf_acc;
  assign cmd_acc = mig.app_en && mig.app_rdy;
  assign wdf_acc = mig.app_wdf_wren && mig.app_wdf_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      lane_q           <= 2'd0;
      is_wr_q          <= 1'b0;
      cmd_done         <= 1'b0;
      wdf_done         <= 1'b0;
      dram_rdata       <= 32'd0;
      dram_valid       <= 1'b0;
      dram_written     <= 1'b0;
      mig.app_addr     <= '0;
      mig.app_cmd      <= 3'b000;
      mig.app_en       <= 1'b0;
      mig.app_wdf_data <= 128'd0;
      mig.app_wdf_mask <= 16'd0;
      mig.app_wdf_wren <= 1'b0;
      mig.app_wdf_end  <= 1'b0;
    end else begin
      dram_valid   <= 1'b0;
      dram_written <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dram_oe) begin
            // Every UI field is computed once here and stays frozen until completion.
            // That keeps the fields stable while their enables wait for acceptance.
            lane_q           <= dram_addr[3:2];
            is_wr_q          <= (dram_we != 4'd0);
            cmd_done         <= 1'b0;
            wdf_done         <= 1'b0;
            mig.app_addr     <= APP_AW'({dram_addr[MEM_SCALE-1:4], 3'b000});
            mig.app_cmd      <= (dram_we == 4'd0) ? 3'b001 : 3'b000;
            mig.app_wdf_data <= {4{dram_wdata}};
            mig.app_wdf_mask <= ~({12'd0, dram_we} << {dram_addr[3:2], 2'b00});
            if (!init_calib_complete) begin
              state <= S_WAIT;
            end else if (dram_we == 4'd0) begin
              state      <= S_RD;
              mig.app_en <= 1'b1;
            end else begin
              state            <= S_WR;
              mig.app_en       <= 1'b1;
              mig.app_wdf_wren <= 1'b1;
              mig.app_wdf_end  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (init_calib_complete) begin
            mig.app_en <= 1'b1;
            if (is_wr_q) begin
              state            <= S_WR;
              mig.app_wdf_wren <= 1'b1;
              mig.app_wdf_end  <= 1'b1;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cmd_acc) begin
            mig.app_en <= 1'b0;
            state      <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (mig.app_rd_data_valid) begin
            dram_rdata <= mig.app_rd_data[32*lane_q +: 32];
            dram_valid <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_WR: begin
          // The command and data channels retire independently, in either order.
          if (cmd_acc) begin
            mig.app_en <= 1'b0;
            cmd_done   <= 1'b1;
          end
          if (wdf_acc) begin
            mig.app_wdf_wren <= 1'b0;
            mig.app_wdf_end  <= 1'b0;
            wdf_done         <= 1'b1;
          end
          if ((cmd_done || cmd_acc) && (wdf_done || wdf_acc)) begin
            dram_written <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_mig_bridge.sv
module tb_dram_mig_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        calib;
  logic        dram_oe;
  logic [26:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_we;
  logic [31:0] dram_rdata;
  logic        dram_valid;
  logic        dram_written;

  int ncmp = 0;
  int nerr = 0;

  dram_mig_bridge_if #(.APP_AW(27)) mig ();

  dram_mig_bridge #(.MEM_SCALE(27), .APP_AW(27)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (calib),
    .dram_oe             (dram_oe),
    .dram_addr           (dram_addr),
    .dram_wdata          (dram_wdata),
    .dram_we             (dram_we),
    .dram_rdata          (dram_rdata),
    .dram_valid          (dram_valid),
    .dram_written        (dram_written),
    .mig                 (mig)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic en_seen;
    logic [26:0] addr_hold;
    rst = 1'b1; calib = 1'b1; dram_oe = 1'b0; dram_addr = '0; dram_wdata = '0; dram_we = '0;
    mig.app_rdy = 1'b0; mig.app_wdf_rdy = 1'b0; mig.app_rd_data = '0; mig.app_rd_data_valid = 1'b0;
    tick(); tick(); tick();
    chk("rst_app_en", mig.app_en, 1'b0);
    chk("rst_wren", mig.app_wdf_wren, 1'b0);
    chk("rst_valid", dram_valid, 1'b0);
    chk("rst_written", dram_written, 1'b0);
    chk("rst_rdata", dram_rdata, 32'd0);
    chk("rst_addr", mig.app_addr, 27'd0);
    chk("rst_mask", mig.app_wdf_mask, 16'd0);
    rst = 1'b0;
    tick();

    // Read of lane 2
    dram_oe = 1'b1; dram_addr = 27'h0A8; dram_we = 4'd0; mig.app_rdy = 1'b1;
    tick();
    dram_oe = 1'b0;
    chk("rd_en", mig.app_en, 1'b1);
    chk("rd_cmd", mig.app_cmd, 3'b001);
    chk("rd_addr", mig.app_addr, 27'h50);
    chk("rd_wren", mig.app_wdf_wren, 1'b0);
    tick();
    chk("rd_en_drop", mig.app_en, 1'b0);
    mig.app_rd_data = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    mig.app_rd_data_valid = 1'b1;
    tick();
    mig.app_rd_data_valid = 1'b0;
    chk("rd_valid", dram_valid, 1'b1);
    chk("rd_data", dram_rdata, 32'hCCCCCCCC);
    chk("rd_written", dram_written, 1'b0);
    tick();
    chk("rd_valid_pulse", dram_valid, 1'b0);

    // Write of lane 3, both channels accept at once
    dram_oe = 1'b1; dram_addr = 27'h00C; dram_we = 4'b0011; dram_wdata = 32'h12345678;
    mig.app_rdy = 1'b1; mig.app_wdf_rdy = 1'b1;
    tick();
    dram_oe = 1'b0;
    chk("wr_en", mig.app_en, 1'b1);
    chk("wr_wren", mig.app_wdf_wren, 1'b1);
    chk("wr_end", mig.app_wdf_end, 1'b1);
    chk("wr_cmd", mig.app_cmd, 3'b000);
    chk("wr_addr", mig.app_addr, 27'h0);
    chk("wr_mask", mig.app_wdf_mask, 16'hCFFF);
    chk("wr_data", mig.app_wdf_data, {4{32'h12345678}});
    tick();
    chk("wr_written", dram_written, 1'b1);
    chk("wr_en_drop", mig.app_en, 1'b0);
    chk("wr_wren_drop", mig.app_wdf_wren, 1'b0);
    tick();
    chk("wr_written_pulse", dram_written, 1'b0);

    // Write with the command channel stalled for 5 cycles
    mig.app_rdy = 1'b0; mig.app_wdf_rdy = 1'b1;
    dram_oe = 1'b1; dram_addr = 27'h1234; dram_we = 4'b1111; dram_wdata = 32'hCAFEF00D;
    tick();
    dram_oe = 1'b0;
    chk("st_en1", mig.app_en, 1'b1);
    chk("st_wren1", mig.app_wdf_wren, 1'b1);
    chk("st_mask", mig.app_wdf_mask, 16'hFF0F);
    chk("st_addr1", mig.app_addr, 27'h918);
    tick();
    chk("st_wren_drop", mig.app_wdf_wren, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("st_en_hold", mig.app_en, 1'b1);
      chk("st_addr_hold", mig.app_addr, 27'h918);
      chk("st_no_written", dram_written, 1'b0);
      tick();
    end
    chk("st_en5", mig.app_en, 1'b1);
    mig.app_rdy = 1'b1;
    tick();
    chk("st_written", dram_written, 1'b1);
    chk("st_en_drop", mig.app_en, 1'b0);
    tick();
    chk("st_written_pulse", dram_written, 1'b0);

    // Calibration not yet complete at the request
    calib = 1'b0;
    dram_oe = 1'b1; dram_addr = 27'h040; dram_we = 4'd0;
    tick();
    dram_oe = 1'b0;
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mig.app_en) en_seen = 1'b1;
      tick();
    end
    chk("cal_no_en", en_seen, 1'b0);
    calib = 1'b1;
    tick();
    chk("cal_en", mig.app_en, 1'b1);
    chk("cal_addr", mig.app_addr, 27'h20);
    tick();
    mig.app_rd_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h0BADF00D};
    mig.app_rd_data_valid = 1'b1;
    tick();
    mig.app_rd_data_valid = 1'b0;
    chk("cal_valid", dram_valid, 1'b1);
    chk("cal_data", dram_rdata, 32'h0BADF00D);

    // Back-to-back: a write strobed in the dram_valid cycle
    tick();
    dram_oe = 1'b1; dram_addr = 27'h01C; dram_we = 4'd0;
    tick();
    dram_oe = 1'b0;
    chk("bb_rd_addr", mig.app_addr, 27'h8);
    tick();
    mig.app_rd_data = {32'h76543210, 32'h0, 32'h0, 32'h0};
    mig.app_rd_data_valid = 1'b1;
    tick();
    mig.app_rd_data_valid = 1'b0;
    chk("bb_rd_valid", dram_valid, 1'b1);
    chk("bb_rd_data", dram_rdata, 32'h76543210);
    dram_oe = 1'b1; dram_addr = 27'h024; dram_we = 4'b0100; dram_wdata = 32'hAABBCCDD;
    tick();
    dram_oe = 1'b0;
    chk("bb_valid_pulse", dram_valid, 1'b0);
    chk("bb_wr_en", mig.app_en, 1'b1);
    chk("bb_wr_wren", mig.app_wdf_wren, 1'b1);
    chk("bb_wr_addr", mig.app_addr, 27'h10);
    chk("bb_wr_mask", mig.app_wdf_mask, 16'hFFBF);
    tick();
    chk("bb_written", dram_written, 1'b1);
    chk("bb_rdata_hold", dram_rdata, 32'h76543210);

    // Reset while waiting for read data; the late beat must be dropped
    tick();
    dram_oe = 1'b1; dram_addr = 27'h028; dram_we = 4'd0;
    tick();
    dram_oe = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_en", mig.app_en, 1'b0);
    tick();
    mig.app_rd_data = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    mig.app_rd_data_valid = 1'b1;
    tick();
    mig.app_rd_data_valid = 1'b0;
    chk("ab_no_valid", dram_valid, 1'b0);
    chk("ab_rdata", dram_rdata, 32'd0);
    tick();
    chk("ab_no_valid2", dram_valid, 1'b0);
    dram_oe = 1'b1; dram_addr = 27'h028; dram_we = 4'd0;
    tick();
    dram_oe = 1'b0;
    chk("ab_rd_en", mig.app_en, 1'b1);
    tick();
    mig.app_rd_data = {32'h0, 32'h600DCAFE, 32'h0, 32'h0};
    mig.app_rd_data_valid = 1'b1;
    tick();
    mig.app_rd_data_valid = 1'b0;
    chk("ab_rd_valid", dram_valid, 1'b1);
    chk("ab_rd_data", dram_rdata, 32'h600DCAFE);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && dram_valid && dram_written) begin
      ncmp++;
      nerr++;
      $error("FAIL both_pulses: observed valid=1 written=1 required not both");
    end
  end

endmodule
